// File: rtl/memory_access_stage.sv
// Memory stage: issues loads/stores over a valid/grant/response data-memory port and registers the M/W pipeline register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module memory_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        validM,
    input  logic        flushM,
    input  logic        regWriteM,
    input  logic        resultSrcM,
    input  logic        memWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] aluResultM,
    input  logic [31:0] writeDataM,
    input  logic [31:0] loadPCResultM,
    input  logic [4:0]  RDM,
    output logic        stallM,
    output logic        regWriteW,
    output logic        resultSrcW,
    output logic [31:0] loadPCResultW,
    output logic [31:0] readDataW,
    output logic [4:0]  RDW,
    output logic        misalignW,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata
);
    // Handshake: dm_req with stable fields until dm_gnt; one dm_rvalid per granted load.
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, lpc_q, lpc_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d, reg_write_q, reg_write_d, result_src_q, result_src_d;
    logic        kill_q, kill_d;

    logic        rw_w_q, rw_w_d, rs_w_q, rs_w_d, mis_w_q, mis_w_d;
    logic [31:0] lpc_w_q, lpc_w_d, read_w_q, read_w_d;
    logic [4:0]  rd_w_q, rd_w_d;

    logic        mem_op, misalign, issue, stall, complete;
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_f3;

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  lane_be = 4'b0001 << off;
            3'b001:  lane_be = 4'b0011 << {off[1], 1'b0};
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  lane_wdata = {4{d[7:0]}};
            3'b001:  lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'b0, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'b0, h};
            default: load_extract = word;
        endcase
    endfunction

    assign mem_op = validM & (resultSrcM | memWriteM);
`ifdef MEM_MISALIGN_TRAP_EN
    // Size is funct3[1:0]: 00 byte, 01 half, 1x word.
    assign misalign = mem_op & ~flushM &
                      (((funct3M[1:0] == 2'b01) & aluResultM[0]) |
                       (funct3M[1] & (aluResultM[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif
    assign issue = mem_op & ~flushM & ~misalign;

    // In IDLE the request is built straight from M; afterwards from the latched copy.
    assign cur_addr  = (state_q == IDLE) ? aluResultM : addr_q;
    assign cur_f3    = (state_q == IDLE) ? funct3M    : f3_q;
    assign cur_wdata = (state_q == IDLE) ? writeDataM : wdata_q;

    assign dm_we    = (state_q == IDLE) ? memWriteM : we_q;
    assign dm_addr  = {cur_addr[31:2], 2'b00};
    assign dm_be    = lane_be(cur_f3, cur_addr[1:0]);
    assign dm_wdata = lane_wdata(cur_f3, cur_wdata);
    assign stallM   = stall;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        f3_d         = f3_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        lpc_d        = lpc_q;
        rd_d         = rd_q;
        kill_d       = kill_q;
        dm_req       = 1'b0;
        stall        = 1'b0;
        complete     = 1'b0;
        rw_w_d       = 1'b0;
        rs_w_d       = 1'b0;
        lpc_w_d      = 32'b0;
        read_w_d     = 32'b0;
        rd_w_d       = 5'b0;
        mis_w_d      = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d       = aluResultM;
                f3_d         = funct3M;
                wdata_d      = writeDataM;
                we_d         = memWriteM;
                reg_write_d  = regWriteM;
                result_src_d = resultSrcM;
                lpc_d        = loadPCResultM;
                rd_d         = RDM;
                kill_d       = 1'b0;
                if (issue) begin
                    dm_req = 1'b1;
                    if (!dm_gnt) begin
                        state_d = REQ;
                        stall   = 1'b1;
                    end else if (!memWriteM) begin
                        state_d = WAIT_RESP;
                        stall   = 1'b1;
                    end
                end
                if (!stall && validM && !flushM) begin
                    rw_w_d  = regWriteM & ~misalign;
                    rs_w_d  = resultSrcM;
                    lpc_w_d = misalign ? aluResultM : loadPCResultM;
                    rd_w_d  = RDM;
                    mis_w_d = misalign;
                end
            end
            REQ: begin
                dm_req = 1'b1;
                kill_d = kill_q | flushM;
                if (!dm_gnt) begin
                    stall = 1'b1;
                end else if (we_q) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end else begin
                    state_d = WAIT_RESP;
                    stall   = 1'b1;
                end
            end
            WAIT_RESP: begin
                kill_d = kill_q | flushM;
                if (dm_rvalid) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                    read_w_d = load_extract(f3_q, addr_q[1:0], dm_rdata);
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A flush seen at any point of an accepted access only kills the register write.
        if (complete) begin
            rw_w_d  = reg_write_q & ~kill_d;
            rs_w_d  = result_src_q;
            lpc_w_d = lpc_q;
            rd_w_d  = rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'b0;
            f3_q         <= 3'b0;
            wdata_q      <= 32'b0;
            we_q         <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            lpc_q        <= 32'b0;
            rd_q         <= 5'b0;
            kill_q       <= 1'b0;
            rw_w_q       <= 1'b0;
            rs_w_q       <= 1'b0;
            lpc_w_q      <= 32'b0;
            read_w_q     <= 32'b0;
            rd_w_q       <= 5'b0;
            mis_w_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            f3_q         <= f3_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            lpc_q        <= lpc_d;
            rd_q         <= rd_d;
            kill_q       <= kill_d;
            rw_w_q       <= rw_w_d;
            rs_w_q       <= rs_w_d;
            lpc_w_q      <= lpc_w_d;
            read_w_q     <= read_w_d;
            rd_w_q       <= rd_w_d;
            mis_w_q      <= mis_w_d;
        end
    end

    assign regWriteW     = rw_w_q;
    assign resultSrcW    = rs_w_q;
    assign loadPCResultW = lpc_w_q;
    assign readDataW     = read_w_q;
    assign RDW           = rd_w_q;
    assign misalignW     = mis_w_q;
endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios plus randomized loads/stores against a
// size/lane reference model.
module tb_memory_access_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        validM = 1'b0, flushM = 1'b0, regWriteM = 1'b0, resultSrcM = 1'b0, memWriteM = 1'b0;
    logic [2:0]  funct3M = 3'b0;
    logic [31:0] aluResultM = 32'b0, writeDataM = 32'b0, loadPCResultM = 32'b0;
    logic [4:0]  RDM = 5'b0;
    logic        stallM, regWriteW, resultSrcW, misalignW, dm_req, dm_we;
    logic [31:0] loadPCResultW, readDataW, dm_addr, dm_wdata;
    logic [4:0]  RDW;
    logic [3:0]  dm_be;
    logic        dm_gnt = 1'b0, dm_rvalid = 1'b0;
    logic [31:0] dm_rdata = 32'b0;

    int n_cmp = 0;
    int n_err = 0;

    memory_access_stage dut (
        .clk(clk), .rst(rst), .validM(validM), .flushM(flushM), .regWriteM(regWriteM),
        .resultSrcM(resultSrcM), .memWriteM(memWriteM), .funct3M(funct3M), .aluResultM(aluResultM),
        .writeDataM(writeDataM), .loadPCResultM(loadPCResultM), .RDM(RDM), .stallM(stallM),
        .regWriteW(regWriteW), .resultSrcW(resultSrcW), .loadPCResultW(loadPCResultW),
        .readDataW(readDataW), .RDW(RDW), .misalignW(misalignW), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int be_size(input logic [2:0] f3);
        be_size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    endfunction

    function automatic int ld_size(input logic [2:0] f3);
        ld_size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz, lane;
        sz = be_size(f3);
        lane = int'(addr % 4) - int'(addr % 4) % sz;
        model_be = 4'(((1 << sz) - 1) << lane);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        longint unit, w;
        int sz;
        sz = be_size(f3);
        unit = longint'(d) % (64'd1 << (8 * sz));
        w = 0;
        for (int k = 0; k < 4 / sz; k++) w = w + (unit << (8 * sz * k));
        model_wdata = 32'(w);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        longint v, span;
        int sz, lane;
        sz = ld_size(f3);
        lane = int'(addr % 4) - int'(addr % 4) % sz;
        span = 64'd1 << (8 * sz);
        v = (longint'(word) >> (8 * lane)) % span;
        if (f3 < 3'd4 && sz < 4 && v >= span / 2) v = v - span;
        model_load = 32'(v);
    endfunction

    // ---------------- driver ----------------
    // Presents one instruction in M, plays the memory side (grant after gd cycles, response rvd cycles
    // after grant, junk rvalid before grant), returns just after the edge that moved it into W.
    task automatic drive_op(input logic rs, input logic mw, input logic rw, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] lpc,
                            input logic [4:0] rd, input int gd, input int rvd, input int flush_c,
                            input logic [31:0] rdata, output int stalls, output logic req_seen,
                            output logic [3:0] be_s, output logic [31:0] wd_s, output logic [31:0] ad_s,
                            output logic we_s);
        logic granted, done;
        int gc;
        validM = 1'b1; resultSrcM = rs; memWriteM = mw; regWriteM = rw; funct3M = f3;
        aluResultM = addr; writeDataM = wdata; loadPCResultM = lpc; RDM = rd;
        stalls = 0; req_seen = 1'b0; be_s = 4'b0; wd_s = 32'b0; ad_s = 32'b0; we_s = 1'b0;
        granted = 1'b0; done = 1'b0; gc = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            flushM = (flush_c >= 0 && c >= flush_c);
            dm_gnt = (!granted && c == gd);
            if (granted && c == gc + rvd) begin
                dm_rvalid = 1'b1;
                dm_rdata  = rdata;
            end else begin
                dm_rvalid = granted ? 1'b0 : 1'($urandom_range(0, 1));
                dm_rdata  = $urandom;
            end
            #1;
            if (dm_req) req_seen = 1'b1;
            if (dm_req && dm_gnt) begin
                granted = 1'b1; gc = c;
                be_s = dm_be; wd_s = dm_wdata; ad_s = dm_addr; we_s = dm_we;
            end
            if (stallM) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL drive_op_timeout: stallM still 1 after 60 cycles, required completion");
        end
        validM = 1'b0; flushM = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0;
        resultSrcM = 1'b0; memWriteM = 1'b0; regWriteM = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({stallM, dm_req, regWriteW, resultSrcW, misalignW} !== 5'b0 || readDataW !== 32'b0 ||
            loadPCResultW !== 32'b0 || RDW !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: stall=%b req=%b rw=%b rs=%b mis=%b rd=%h lpc=%h rdw=%0d, required all 0",
                     stallM, dm_req, regWriteW, resultSrcW, misalignW, readDataW, loadPCResultW, RDW);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_pass();
        int st; logic rq, we; logic [3:0] be; logic [31:0] wd, ad;
        drive_op(1'b0, 1'b0, 1'b1, 3'd0, 32'h40, 32'h0, 32'h1234, 5'd5, 0, 1, -1, 32'h0, st, rq, be, wd, ad, we);
        n_cmp++;
        if (st !== 0 || rq !== 1'b0 || regWriteW !== 1'b1 || RDW !== 5'd5 || loadPCResultW !== 32'h1234) begin
            n_err++;
            $display("FAIL alu_add: stalls=%0d req=%b rw=%b rd=%0d lpc=%h, required 0 0 1 5 1234",
                     st, rq, regWriteW, RDW, loadPCResultW);
        end
        for (int i = 0; i < 4; i++) begin
            logic rw_r; logic [31:0] lpc_r; logic [4:0] rd_r;
            rw_r = 1'($urandom_range(0, 1)); lpc_r = $urandom; rd_r = 5'($urandom);
            drive_op(1'b0, 1'b0, rw_r, 3'($urandom), $urandom, $urandom, lpc_r, rd_r,
                     $urandom_range(0, 2), 1, -1, 32'h0, st, rq, be, wd, ad, we);
            n_cmp++;
            if (st !== 0 || rq !== 1'b0 || regWriteW !== rw_r || RDW !== rd_r || loadPCResultW !== lpc_r ||
                resultSrcW !== 1'b0) begin
                n_err++;
                $display("FAIL alu_random: stalls=%0d req=%b rw=%b rd=%0d lpc=%h rs=%b, required 0 0 %b %0d %h 0",
                         st, rq, regWriteW, RDW, loadPCResultW, resultSrcW, rw_r, rd_r, lpc_r);
            end
        end
    endtask

    task automatic test_store_byte();
        int st; logic rq, we; logic [3:0] be; logic [31:0] wd, ad;
        drive_op(1'b0, 1'b1, 1'b0, 3'd0, 32'h103, 32'h123456AB, 32'h0, 5'd0, 0, 1, -1, 32'h0,
                 st, rq, be, wd, ad, we);
        n_cmp++;
        if (be !== 4'b1000 || wd !== 32'hABABABAB || ad !== 32'h100 || we !== 1'b1 || st !== 0 ||
            regWriteW !== 1'b0) begin
            n_err++;
            $display("FAIL store_byte: be=%b wdata=%h addr=%h we=%b stalls=%0d rw=%b, required 1000 abababab 100 1 0 0",
                     be, wd, ad, we, st, regWriteW);
        end
    endtask

    task automatic test_load_half_stall();
        int st; logic rq, we; logic [3:0] be; logic [31:0] wd, ad;
        drive_op(1'b1, 1'b0, 1'b1, 3'd1, 32'h202, 32'h0, 32'h0, 5'd9, 2, 3, -1, 32'h80010000,
                 st, rq, be, wd, ad, we);
        n_cmp++;
        if (st !== 5 || readDataW !== 32'hFFFF8001 || resultSrcW !== 1'b1 || regWriteW !== 1'b1 ||
            RDW !== 5'd9 || be !== 4'b1100 || ad !== 32'h200) begin
            n_err++;
            $display("FAIL load_half: stalls=%0d data=%h rs=%b rw=%b rd=%0d be=%b addr=%h, required 5 ffff8001 1 1 9 1100 200",
                     st, readDataW, resultSrcW, regWriteW, RDW, be, ad);
        end
    endtask

    task automatic test_lbu();
        int st; logic rq, we; logic [3:0] be; logic [31:0] wd, ad;
        drive_op(1'b1, 1'b0, 1'b1, 3'd4, 32'h3, 32'h0, 32'h0, 5'd3, 0, 1, -1, 32'h9F000000,
                 st, rq, be, wd, ad, we);
        n_cmp++;
        if (readDataW !== 32'h0000009F || st !== 1 || be !== model_be(3'd4, 32'h3)) begin
            n_err++;
            $display("FAIL load_lbu: data=%h stalls=%0d be=%b, required 0000009f 1 %b",
                     readDataW, st, be, model_be(3'd4, 32'h3));
        end
    endtask

    task automatic test_flush();
        int st; logic rq, we; logic [3:0] be; logic [31:0] wd, ad;
        drive_op(1'b1, 1'b0, 1'b1, 3'd2, 32'h40, 32'h0, 32'h0, 5'd7, 0, 3, 1, 32'hCAFE0007,
                 st, rq, be, wd, ad, we);
        n_cmp++;
        if (st !== 3 || rq !== 1'b1 || regWriteW !== 1'b0 || readDataW !== 32'hCAFE0007) begin
            n_err++;
            $display("FAIL flush_wait: stalls=%0d req=%b rw=%b data=%h, required 3 1 0 cafe0007",
                     st, rq, regWriteW, readDataW);
        end
        drive_op(1'b1, 1'b0, 1'b1, 3'd2, 32'h44, 32'h0, 32'h0, 5'd8, 0, 1, 0, 32'h0,
                 st, rq, be, wd, ad, we);
        n_cmp++;
        if (st !== 0 || rq !== 1'b0 || regWriteW !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle: stalls=%0d req=%b rw=%b, required 0 0 0", st, rq, regWriteW);
        end
    endtask

    task automatic test_random_access();
        int st, gd, rvd, sz; logic rq, we, is_st, rw_r; logic [3:0] be; logic [31:0] wd, ad;
        logic [2:0] f3; logic [31:0] addr, data, rdata, lpc_r; logic [4:0] rd_r;
        for (int i = 0; i < 24; i++) begin
            is_st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            sz = is_st ? be_size(f3) : ld_size(f3);
            addr = $urandom & 32'h0000FFFF;
            addr = addr - addr % sz;
            data = $urandom; rdata = $urandom; lpc_r = $urandom; rd_r = 5'($urandom);
            rw_r = is_st ? 1'b0 : 1'b1;
            gd = $urandom_range(0, 3); rvd = $urandom_range(1, 3);
            drive_op(!is_st, is_st, rw_r, f3, addr, data, lpc_r, rd_r, gd, rvd, -1, rdata,
                     st, rq, be, wd, ad, we);
            n_cmp++;
            if (be !== model_be(f3, addr) || ad !== (addr - addr % 4) || we !== is_st ||
                st !== (is_st ? gd : gd + rvd) || regWriteW !== rw_r || RDW !== rd_r ||
                loadPCResultW !== lpc_r) begin
                n_err++;
                $display("FAIL random_req: f3=%0d addr=%h st=%b be=%b/%b addr=%h we=%b stalls=%0d/%0d rw=%b rd=%0d lpc=%h",
                         f3, addr, is_st, be, model_be(f3, addr), ad, we, st, is_st ? gd : gd + rvd,
                         regWriteW, RDW, loadPCResultW);
            end
            n_cmp++;
            if (is_st ? (wd !== model_wdata(f3, data)) : (readDataW !== model_load(f3, addr, rdata))) begin
                n_err++;
                $display("FAIL random_data: f3=%0d addr=%h store=%b got wdata=%h rdataW=%h, required %h",
                         f3, addr, is_st, wd, readDataW,
                         is_st ? model_wdata(f3, data) : model_load(f3, addr, rdata));
            end
        end
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        validM = 1'b1; resultSrcM = 1'b1; regWriteM = 1'b1; memWriteM = 1'b0; funct3M = 3'd2;
        aluResultM = 32'h6; loadPCResultM = 32'h99; RDM = 5'd4; dm_gnt = 1'b1;
        #1;
        n_cmp++;
        if (dm_req !== 1'b0 || stallM !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_issue: req=%b stall=%b, required 0 0", dm_req, stallM);
        end
        @(posedge clk); #1;
        validM = 1'b0; dm_gnt = 1'b0; resultSrcM = 1'b0; regWriteM = 1'b0;
        n_cmp++;
        if (misalignW !== 1'b1 || regWriteW !== 1'b0 || loadPCResultW !== 32'h6) begin
            n_err++;
            $display("FAIL misalign_w: mis=%b rw=%b lpc=%h, required 1 0 00000006",
                     misalignW, regWriteW, loadPCResultW);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (misalignW !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_one_cycle: mis=%b, required 0", misalignW);
        end
`else
        int st; logic rq, we; logic [3:0] be; logic [31:0] wd, ad;
        drive_op(1'b1, 1'b0, 1'b1, 3'd2, 32'h6, 32'h0, 32'h0, 5'd4, 0, 1, -1, 32'h11223344,
                 st, rq, be, wd, ad, we);
        n_cmp++;
        if (be !== 4'b1111 || ad !== 32'h4 || readDataW !== 32'h11223344 || misalignW !== 1'b0 ||
            regWriteW !== 1'b1) begin
            n_err++;
            $display("FAIL misalign_word_nocheck: be=%b addr=%h data=%h mis=%b rw=%b, required 1111 4 11223344 0 1",
                     be, ad, readDataW, misalignW, regWriteW);
        end
        drive_op(1'b1, 1'b0, 1'b1, 3'd1, 32'h203, 32'h0, 32'h0, 5'd4, 1, 2, -1, 32'hBEEF1234,
                 st, rq, be, wd, ad, we);
        n_cmp++;
        if (be !== 4'b1100 || readDataW !== 32'hFFFFBEEF || misalignW !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_half_nocheck: be=%b data=%h mis=%b, required 1100 ffffbeef 0",
                     be, readDataW, misalignW);
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        validM = 1'b1; resultSrcM = 1'b1; regWriteM = 1'b1; funct3M = 3'd2; aluResultM = 32'h80;
        RDM = 5'd6; loadPCResultM = 32'h55; dm_gnt = 1'b1;
        @(posedge clk); #1;
        validM = 1'b0; resultSrcM = 1'b0; regWriteM = 1'b0; dm_gnt = 1'b0; rst = 1'b1;
        #1;
        n_cmp++;
        if (stallM !== 1'b1 || dm_req !== 1'b0) begin
            n_err++;
            $display("FAIL wait_resp_entry: stall=%b req=%b, required 1 0", stallM, dm_req);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({stallM, dm_req, regWriteW, resultSrcW, misalignW} !== 5'b0 || readDataW !== 32'b0 ||
            loadPCResultW !== 32'b0 || RDW !== 5'b0) begin
            n_err++;
            $display("FAIL reset_mid_access: stall=%b req=%b rw=%b rs=%b mis=%b data=%h lpc=%h rd=%0d, required all 0",
                     stallM, dm_req, regWriteW, resultSrcW, misalignW, readDataW, loadPCResultW, RDW);
        end
        dm_rvalid = 1'b1; dm_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        dm_rvalid = 1'b0;
        n_cmp++;
        if (stallM !== 1'b0 || readDataW !== 32'b0) begin
            n_err++;
            $display("FAIL reset_abandons: stall=%b data=%h, required 0 00000000", stallM, readDataW);
        end
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_store_byte();
        test_load_half_stall();
        test_lbu();
        test_flush();
        test_random_access();
        test_misalign();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory stage of the five-stage core: takes the instruction leaving execute, performs its load or store over a valid/grant/response data-memory handshake, and registers the result into the M/W pipeline register that feeds writeback. It handles byte-lane alignment, store byte enables, load sign/zero extension, and stalls the pipeline while an access is outstanding. Writeback consumes `regWriteW`, `resultSrcW`, `loadPCResultW`, `readDataW` and `RDW` directly from this block.

## Interface
- No parameters.
- `clk`  in  1  core clock; one clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `validM`, `flushM`  in  1 each  instruction valid in M / kill it.
- `regWriteM`, `resultSrcM`, `memWriteM`  in  1 each  RF write, result is load data, instruction is store.
- `funct3M`  in  3  access size/sign.
- `aluResultM`  in  32  effective address.
- `writeDataM`  in  32  store data.
- `loadPCResultM`  in  32  ALU/PC+4 result.
- `RDM`  in  5  destination register.
- `stallM`  out  1  M cannot advance; upstream holds.
- `regWriteW`, `resultSrcW`  out  1 each  to writeback.
- `loadPCResultW`, `readDataW`  out  32 each  to writeback.
- `RDW`  out  5  to writeback.
- `misalignW`  out  1  misaligned access flagged (see Configuration).
- `dm_req`, `dm_we`  out  1 each  request valid, write.
- `dm_addr`  out  32  word-aligned address.
- `dm_wdata`  out  32  lane-replicated store data.
- `dm_be`  out  4  byte enables.
- `dm_gnt`  in  1  request accepted this cycle.
- `dm_rvalid`  in  1  load data valid.
- `dm_rdata`  in  32  load data word.

## Operation
- Memory op = `validM & (resultSrcM | memWriteM)`; everything else passes through.
- FSM: IDLE, REQ, WAIT_RESP.
  - IDLE: memory op → `dm_req`=1 combinationally; `dm_gnt` same cycle → store done (→IDLE), load → WAIT_RESP; no grant → REQ.
  - REQ: `dm_req` held with stable fields until `dm_gnt`; then as above.
  - WAIT_RESP: `dm_req`=0; on `dm_rvalid` capture data, → IDLE.
- `stallM` = 1 in IDLE/REQ without grant, in REQ until grant, in WAIT_RESP until `dm_rvalid`.
- `dm_addr` = {`aluResultM`[31:2],2'b00}; `dm_we` = `memWriteM`.
- funct3 000 byte: `dm_be` = 4'b0001 << addr[1:0], wdata = byte ×4. 001 half: 4'b0011 << {addr[1],0}, wdata = half ×2. 010 and any other code: 4'b1111, full word. Loads drive `dm_be` the same way.
- Load extraction: 000 LB sign, 100 LBU zero, 001 LH sign, 101 LHU zero, 010/other LW; lane chosen by latched addr[1:0].
- M/W register loads on every cycle `stallM`=0; while `stallM`=1 it loads a bubble (`regWriteW`=0, `misalignW`=0).
- Flush: `flushM` in IDLE suppresses the request, a bubble advances. `flushM` in REQ/WAIT_RESP: the access completes (memory cannot be cancelled), but the result advances with `regWriteW`=0.

## Timing
- Non-memory op and granted store: 1 cycle M→W.
- Load with grant in cycle 0: `dm_rvalid` earliest cycle 1; result in W the edge after `dm_rvalid`.
- `dm_rvalid` is never accepted in IDLE/REQ (ignored).
- Reset: state IDLE, `dm_req`=0, `stallM`=0, all W outputs 0 (`regWriteW`=0, `resultSrcW`=0, `readDataW`=0, `loadPCResultW`=0, `RDW`=0, `misalignW`=0). Reset mid-access abandons it; memory is reset by the same `rst`.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: half access with addr[0]=1 or word with addr[1:0]≠0 issues no `dm_req`, no stall; it advances with `regWriteW`=0 and `misalignW`=1 for one W cycle, `loadPCResultW`=address.
- Undefined: no check, `misalignW` tied 0; the access is issued with the ignored low bits treated as 0 (half uses addr[1] only, word uses 4'b1111).

## Test plan
- ADD through M (`loadPCResultM`=0x1234, `RDM`=5), `dm_gnt` irrelevant → next cycle `regWriteW`=1, `RDW`=5, `loadPCResultW`=0x1234, `dm_req`=0.
- SB addr 0x103, data 0xAB, `dm_gnt`=1 → `dm_be`=4'b1000, `dm_wdata`=0xABABABAB, `dm_addr`=0x100, no stall.
- LH addr 0x202, `dm_gnt` after 2 cycles, `dm_rvalid` 3 cycles later with 0x8001_0000 → `stallM` high for 5 cycles, `readDataW`=0xFFFF8001, `resultSrcW`=1.
- LBU addr 0x3, `dm_rdata`=0x9F000000 → `readDataW`=0x0000009F.
- `flushM` during WAIT_RESP of a load to x7 → access completes, `regWriteW`=0.
- With `MEM_MISALIGN_TRAP_EN`, LW addr 0x6 → no `dm_req`, `misalignW`=1, `regWriteW`=0, `loadPCResultW`=0x6. `rst` asserted in WAIT_RESP → next cycle IDLE, all outputs 0.
